// File: rtl/grid_pkg.sv
// Shared constants and types for the grid cell-state memory and its clear controller.
// Types and widths only; no logic.
package grid_pkg;

    localparam int GRID_DATA_W = 2;
    localparam int GRID_ADDR_W = 14;
    localparam int GRID_DEPTH  = 16384;
    localparam logic [GRID_DATA_W-1:0] GRID_CLEAR_VAL = '0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam logic [GRID_DATA_W-1:0] CELL_EMPTY = 2'd0;
    localparam logic [GRID_DATA_W-1:0] CELL_P1    = 2'd1;
    localparam logic [GRID_DATA_W-1:0] CELL_P2    = 2'd2;
    localparam logic [GRID_DATA_W-1:0] CELL_WALL  = 2'd3;

    // Pointer width for a DEPTH-entry array, never zero.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/grid_mem_clr_ctrl.sv
// Clear-sweep controller: walks clr_ptr over every cell once per reset/clr_req, one cell per cycle.
// Owns the write port while busy; clr_req during a sweep is ignored, reset restarts the sweep.
module grid_clr_ctrl
    import grid_pkg::*;
#(
    parameter int DEPTH = GRID_DEPTH,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req,
    output logic [PTR_W-1:0] clr_ptr,
    output logic             busy,
    output logic             clr_done,
    output logic             clr_sel,
    output logic             port_free
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    clr_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    // Pointer parks on the last cell rather than wrapping.
                    if (clr_ptr == LAST) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == CLEAR);
    assign clr_sel   = busy;
    // A clear request in the same cycle beats a user write.
    assign port_free = (state == IDLE) && !clr_req && !reset;

endmodule

// File: rtl/grid_mem.sv
// Grid cell-state memory, one write port, one read port (latency 1, or 0 with GRID_MEM_COMB_RD_EN), self-timed clear.
// No backpressure: busy/out-of-range reads return CLEAR_VAL, writes during busy or out of range are dropped.
module grid_mem
    import grid_pkg::*;
#(
    parameter int                DATA_W    = GRID_DATA_W,
    parameter int                ADDR_W    = GRID_ADDR_W,
    parameter int                DEPTH     = GRID_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(GRID_CLEAR_VAL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              clr_done
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  clr_ptr;
    logic              clr_sel;
    logic              port_free;
    logic              w_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_word;

    grid_clr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_clr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_ptr   (clr_ptr),
        .busy      (busy),
        .clr_done  (clr_done),
        .clr_sel   (clr_sel),
        .port_free (port_free)
    );

    // One extra bit so DEPTH == 2**ADDR_W compares correctly.
    assign w_in_range  = ({1'b0, w_addr}  < (ADDR_W+1)'(DEPTH));
    assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (clr_sel) begin
            mem[clr_ptr] <= CLEAR_VAL;
        end else if (w_en && port_free && w_in_range) begin
            mem[w_addr[PTR_W-1:0]] <= w_data;
        end
    end

    assign rd_word = (busy || !rd_in_range) ? CLEAR_VAL : mem[rd_addr[PTR_W-1:0]];

`ifdef GRID_MEM_COMB_RD_EN
    assign rd_data  = rd_word;
    assign rd_valid = rd_en;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grid_mem.sv
// Directed bench for grid_mem: a DEPTH=16 instance and a DEPTH=12 instance (CLEAR_VAL=1) share stimulus.
module tb_grid_mem;

    logic       clk;
    logic       reset;
    logic       clr_req;
    logic       w_en;
    logic [3:0] w_addr;
    logic [1:0] w_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       clr_done;
    logic [1:0] rd_data12;
    logic       rd_valid12;
    logic       busy12;
    logic       clr_done12;

    int total = 0;
    int bad   = 0;

    grid_mem #(.DATA_W(2), .ADDR_W(4), .DEPTH(16), .CLEAR_VAL(2'd0)) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .clr_done(clr_done)
    );

    grid_mem #(.DATA_W(2), .ADDR_W(4), .DEPTH(12), .CLEAR_VAL(2'd1)) dut12 (
        .clk(clk), .reset(reset), .clr_req(clr_req),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data12), .rd_valid(rd_valid12),
        .busy(busy12), .clr_done(clr_done12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at posedge+1; returns at posedge+1 with rd_en dropped.
    task automatic rd(input logic [3:0] a, output logic [1:0] d, output logic v,
                      output logic [1:0] d12, output logic v12);
        rd_en   = 1'b1;
        rd_addr = a;
`ifdef GRID_MEM_COMB_RD_EN
        #1;
        d = rd_data; v = rd_valid; d12 = rd_data12; v12 = rd_valid12;
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        d = rd_data; v = rd_valid; d12 = rd_data12; v12 = rd_valid12;
`endif
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] dv);
        w_en = 1'b1; w_addr = a; w_data = dv;
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        logic [1:0] d, d12;
        logic v, v12;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_clr_done got=%b exp=0", clr_done); end
        total++; if (rd_data !== 2'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        repeat (2) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_hold_busy got=%b exp=1", busy); end
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt != 16) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=16", cnt); end
        total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL reset_done_pulse got=%b exp=1", clr_done); end
        @(posedge clk); #1;
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_done_width got=%b exp=0", clr_done); end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d, v, d12, v12);
            total++;
            if (v !== 1'b1 || d !== 2'd0) begin
                bad++; $display("FAIL reset_cleared addr=%0d got=%0d/%b exp=0/1", a, d, v);
            end
        end
    endtask

    task automatic test_write_read;
        logic [1:0] d, d12;
        logic v, v12;
        wr(4'd5, 2'd3);
        rd(4'd5, d, v, d12, v12);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b exp=1", v); end
        total++; if (d !== 2'd3) begin bad++; $display("FAIL wr_rd_data got=%0d exp=3", d); end
        @(posedge clk); #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 2'd3) begin bad++; $display("FAIL rd_idle_hold got=%0d exp=3", rd_data); end
    endtask

    task automatic test_read_first;
        logic [1:0] d, d12;
        logic v, v12;
        wr(4'd7, 2'd1);
        w_en = 1'b1; w_addr = 4'd7; w_data = 2'd2;
        rd_en = 1'b1; rd_addr = 4'd7;
`ifdef GRID_MEM_COMB_RD_EN
        #1; d = rd_data;
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        d = rd_data;
`endif
        w_en = 1'b0; rd_en = 1'b0;
        total++; if (d !== 2'd1) begin bad++; $display("FAIL read_first_old got=%0d exp=1", d); end
        rd(4'd7, d, v, d12, v12);
        total++; if (d !== 2'd2 || v !== 1'b1) begin bad++; $display("FAIL read_first_new got=%0d/%b exp=2/1", d, v); end
    endtask

    task automatic test_clr_wins;
        int cnt;
        logic [1:0] d, d12;
        logic v, v12;
        wr(4'd3, 2'd1);
        clr_req = 1'b1; w_en = 1'b1; w_addr = 4'd3; w_data = 2'd2;
        @(posedge clk); #1;
        clr_req = 1'b0; w_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
`ifndef GRID_MEM_COMB_RD_EN
            if (i == 1) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== 2'd0) begin
                    bad++; $display("FAIL busy_read got=%0d/%b exp=0/1", rd_data, rd_valid);
                end
            end
`endif
            rd_en   = (i == 0);
            rd_addr = 4'd5;
            clr_req = (i == 5);
            w_en    = (i == 12);
            w_addr  = 4'd2;
            w_data  = 2'd3;
`ifdef GRID_MEM_COMB_RD_EN
            if (i == 0) begin
                #1;
                total++;
                if (rd_valid !== 1'b1 || rd_data !== 2'd0) begin
                    bad++; $display("FAIL busy_read got=%0d/%b exp=0/1", rd_data, rd_valid);
                end
            end
`endif
            @(posedge clk); #1;
        end
        rd_en = 1'b0; clr_req = 1'b0; w_en = 1'b0;
        total++; if (cnt != 16) begin bad++; $display("FAIL clr_req_sweep_len got=%0d exp=16", cnt); end
        total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL clr_req_done got=%b exp=1", clr_done); end
        rd(4'd3, d, v, d12, v12);
        total++; if (d !== 2'd0) begin bad++; $display("FAIL clr_beats_write got=%0d exp=0", d); end
        rd(4'd2, d, v, d12, v12);
        total++; if (d !== 2'd0) begin bad++; $display("FAIL busy_write_dropped got=%0d exp=0", d); end
        rd(4'd5, d, v, d12, v12);
        total++; if (d !== 2'd0) begin bad++; $display("FAIL clr_swept_cell got=%0d exp=0", d); end
    endtask

    task automatic test_reset_mid;
        int cnt;
        int early;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        early = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (clr_done === 1'b1) early++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy got=%b exp=1", busy); end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            if (clr_done === 1'b1) early++;
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (early != 0) begin bad++; $display("FAIL mid_reset_no_done got=%0d exp=0", early); end
        total++; if (cnt != 16) begin bad++; $display("FAIL mid_reset_sweep_len got=%0d exp=16", cnt); end
        total++; if (clr_done !== 1'b1) begin bad++; $display("FAIL mid_reset_done got=%b exp=1", clr_done); end
    endtask

    task automatic test_out_of_range;
        logic [1:0] d, d12;
        logic v, v12;
        wr(4'd5, 2'd2);
        wr(4'd13, 2'd3);
        rd(4'd5, d, v, d12, v12);
        total++; if (d12 !== 2'd2 || v12 !== 1'b1) begin bad++; $display("FAIL oor_neighbour got=%0d/%b exp=2/1", d12, v12); end
        rd(4'd13, d, v, d12, v12);
        total++; if (d12 !== 2'd1 || v12 !== 1'b1) begin bad++; $display("FAIL oor_read got=%0d/%b exp=1/1", d12, v12); end
        total++; if (d !== 2'd3) begin bad++; $display("FAIL inrange_13 got=%0d exp=3", d); end
        rd(4'd11, d, v, d12, v12);
        total++; if (d12 !== 2'd1) begin bad++; $display("FAIL last_cell got=%0d exp=1", d12); end
        rd(4'd12, d, v, d12, v12);
        total++; if (d12 !== 2'd1 || v12 !== 1'b1) begin bad++; $display("FAIL oor_depth got=%0d/%b exp=1/1", d12, v12); end
    endtask

    initial begin
        reset = 1'b0; clr_req = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        test_reset;
        test_write_read;
        test_read_first;
        test_clr_wins;
        test_reset_mid;
        test_out_of_range;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
